// File: rtl/input_unpack.sv
// ---------------------------------------------------------------------------
// input_unpack
//   Reads Length consecutive 128-bit words from memory, starting at word
//   address BASE_ADDR, and streams each word out as 16 bytes, most
//   significant byte first, under a valid/ready handshake.
//
// Ports
//   clock        in   sole clock, rising edge
//   reset        in   synchronous active-high reset
//   StartIn      in   level: high = run / keep running, low = abort to idle
//   Length       in   16  word count, sampled when leaving idle
//   ReadBus      in   128 read data, valid the cycle after ReadEnable
//   ReadAddress  out  16  registered word address
//   ReadEnable   out  one-cycle read strobe
//   ByteOut      out  8   current byte
//   ByteValid    out  ByteOut holds a valid byte
//   ByteReady    in   consumer accepts; transfer = ByteValid & ByteReady
//   done         out  high when idle or complete
//
// Build option
//   INPUT_UNPACK_PREFETCH_EN : adds a second 128-bit buffer. The next word
//   is read on the first byte transfer of the current word and swapped in
//   on the last transfer, so bytes stream across word boundaries with no
//   gap. Without it, each word costs a REQ/WAIT bubble of two cycles.
// ---------------------------------------------------------------------------
module input_unpack #(
   parameter logic [15:0] BASE_ADDR = 16'h0000
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          StartIn,
   input  logic [15:0]   Length,
   input  logic [127:0]  ReadBus,
   output logic [15:0]   ReadAddress,
   output logic          ReadEnable,
   output logic [7:0]    ByteOut,
   output logic          ByteValid,
   input  logic          ByteReady,
   output logic          done
);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_DONE} state_t;

   state_t         state_q;
   logic [15:0]    len_q;      // latched word count
   logic [15:0]    rd_idx_q;   // index of the next word to request
   logic [15:0]    wd_idx_q;   // index of the word being drained
   logic [3:0]     p_q;        // byte pointer within the holding word
   logic [127:0]   hold_q;
   logic [15:0]    ra_q;
   logic           re_q;
   logic [7:0]     bo_q;
   logic           bv_q;
   logic           done_q;
`ifdef INPUT_UNPACK_PREFETCH_EN
   logic [127:0]   pf_q;       // next word, filled while the current one drains
   logic           pf_cap_q;   // ReadBus carries prefetch data this cycle
`endif

   logic xfer_d;
   logic last_word_d;
   logic more_reads_d;

   assign xfer_d       = bv_q & ByteReady;
   assign last_word_d  = (wd_idx_q == len_q - 16'd1);
   assign more_reads_d = (rd_idx_q < len_q);

   // Byte p of a word, counted from the most significant end.
   function automatic logic [7:0] pick(input logic [127:0] h, input logic [3:0] idx);
      logic [3:0] s;
      s = 4'd15 - idx;
      return h[{s, 3'b000} +: 8];
   endfunction

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_IDLE;
         len_q    <= '0;
         rd_idx_q <= '0;
         wd_idx_q <= '0;
         p_q      <= '0;
         hold_q   <= '0;
         ra_q     <= '0;
         re_q     <= 1'b0;
         bo_q     <= '0;
         bv_q     <= 1'b0;
         done_q   <= 1'b1;
`ifdef INPUT_UNPACK_PREFETCH_EN
         pf_q     <= '0;
         pf_cap_q <= 1'b0;
`endif
      end else if (!StartIn && state_q != S_IDLE) begin
         // Abort: drop any pending byte and in-flight read.
         state_q  <= S_IDLE;
         re_q     <= 1'b0;
         bv_q     <= 1'b0;
         done_q   <= 1'b1;
`ifdef INPUT_UNPACK_PREFETCH_EN
         pf_cap_q <= 1'b0;
`endif
      end else begin
         re_q <= 1'b0;  // strobe lasts one cycle unless re-armed below
`ifdef INPUT_UNPACK_PREFETCH_EN
         // In DRAIN the strobe can only come from a prefetch.
         pf_cap_q <= re_q && (state_q == S_DRAIN);
         if (pf_cap_q) pf_q <= ReadBus;
`endif
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b1;
               bv_q   <= 1'b0;
               if (StartIn) begin
                  len_q    <= Length;
                  wd_idx_q <= '0;
                  if (Length != 16'd0) begin
                     state_q  <= S_REQ;
                     done_q   <= 1'b0;
                     re_q     <= 1'b1;
                     ra_q     <= BASE_ADDR;
                     rd_idx_q <= 16'd1;
                  end else begin
                     state_q  <= S_DONE;
                  end
               end
            end
            S_REQ: state_q <= S_WAIT;
            S_WAIT: begin
               hold_q  <= ReadBus;
               bo_q    <= ReadBus[127:120];
               bv_q    <= 1'b1;
               p_q     <= '0;
               state_q <= S_DRAIN;
            end
            S_DRAIN: begin
               if (xfer_d) begin
`ifdef INPUT_UNPACK_PREFETCH_EN
                  if (p_q == 4'd0 && more_reads_d) begin
                     re_q     <= 1'b1;
                     ra_q     <= BASE_ADDR + rd_idx_q;
                     rd_idx_q <= rd_idx_q + 16'd1;
                  end
`endif
                  if (p_q == 4'd15) begin
                     if (last_word_d) begin
                        state_q <= S_DONE;
                        bv_q    <= 1'b0;
                        done_q  <= 1'b1;
                     end else begin
                        wd_idx_q <= wd_idx_q + 16'd1;
`ifdef INPUT_UNPACK_PREFETCH_EN
                        // Prefetched word is already in pf_q: no bubble.
                        hold_q <= pf_q;
                        bo_q   <= pf_q[127:120];
                        p_q    <= '0;
`else
                        state_q  <= S_REQ;
                        bv_q     <= 1'b0;
                        re_q     <= 1'b1;
                        ra_q     <= BASE_ADDR + rd_idx_q;
                        rd_idx_q <= rd_idx_q + 16'd1;
`endif
                     end
                  end else begin
                     p_q  <= p_q + 4'd1;
                     bo_q <= pick(hold_q, p_q + 4'd1);
                  end
               end
            end
            S_DONE: begin
               bv_q   <= 1'b0;
               done_q <= 1'b1;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifndef INPUT_UNPACK_PREFETCH_EN
   // Read pacing is entirely state driven in this build.
   logic unused_d;
   assign unused_d = more_reads_d;
`endif

   assign ReadAddress = ra_q;
   assign ReadEnable  = re_q;
   assign ByteOut     = bo_q;
   assign ByteValid   = bv_q;
   assign done        = done_q;

endmodule

// File: doc/input_unpack.md
INPUT_UNPACK -- requirements
Module: input_unpack

Interface
REQ-001 Parameter BASE_ADDR, default 16'h0000, first word address read after start.
REQ-002 clock  input  1  sole clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 StartIn  input  1  level; high = run/keep running, low = abort/return idle.
REQ-005 Length  input  16  number of 128-bit words to read; sampled on idle->active edge only.
REQ-006 ReadBus  input  128  memory read data; valid the cycle after ReadEnable.
REQ-007 ReadAddress  output  16  registered word address.
REQ-008 ReadEnable  output  1  registered one-cycle read strobe.
REQ-009 ByteOut  output  8  registered unpacked byte.
REQ-010 ByteValid  output  1  ByteOut holds a valid byte.
REQ-011 ByteReady  input  1  consumer accepts; transfer = ByteValid & ByteReady at an edge.
REQ-012 done  output  1  high when idle or complete, low while active.

Function
REQ-013 States: IDLE, REQ, WAIT, DRAIN, DONE; exactly one active.
REQ-014 IDLE: done=1, ReadEnable=0, ByteValid=0; StartIn=1 with Length!=0 -> REQ, word index=0, length latched; StartIn=1 with Length=0 -> DONE, no reads.
REQ-015 REQ: ReadEnable=1, ReadAddress=BASE_ADDR+word index (mod 2^16), one cycle -> WAIT.
REQ-016 WAIT: ReadBus captured into 128-bit holding register at end of cycle -> DRAIN, byte pointer=0.
REQ-017 DRAIN: ByteOut = holding[127-8p : 120-8p], p=byte pointer 0..15; most-significant byte first.
REQ-018 ByteOut and ByteValid stable while ByteValid=1 and ByteReady=0.
REQ-019 Each transfer advances p by 1; transfer at p=15 completes the word.
REQ-020 Word complete with words remaining -> REQ (word index+1); last word complete -> DONE.
REQ-021 DONE: done=1, ByteValid=0, ReadEnable=0; hold until StartIn=0 -> IDLE.
REQ-022 Latency: StartIn sampled high at edge 0 -> ReadEnable high cycle 1 -> first ByteValid cycle 3.
REQ-023 StartIn=0 in any non-IDLE state -> IDLE at next edge; pending byte discarded, no further reads, done=1 next cycle.
REQ-024 Word index 16 bits; address wraps 16'hFFFF -> 16'h0000 without error.
REQ-025 ByteReady while ByteValid=0 has no effect.

Reset
REQ-026 reset=1 at an edge -> IDLE, done=1, ReadEnable=0, ByteValid=0, ReadAddress=16'h0000, ByteOut=8'h00, p=0, word index=0, holding/prefetch registers cleared.
REQ-027 reset overrides StartIn and any in-flight read; ReadBus ignored in the cycle after reset.

Configuration
REQ-028 Macro INPUT_UNPACK_PREFETCH_EN.
REQ-029 Defined: second 128-bit buffer; next word read issued on the first transfer of the current word (if words remain); on p=15 transfer the buffer moves to holding with no bubble -- continuous ByteValid across words when ByteReady stays high.
REQ-030 Undefined: single buffer; REQ/WAIT between words -> exactly 2 ByteValid-low cycles between words.
REQ-031 Both builds: identical byte order, reset values, abort behaviour, ReadEnable count = Length.

Verification
REQ-032 Length=1, BASE_ADDR=0, ReadBus=128'h00112233_44556677_8899AABB_CCDDEEFF, ByteReady=1 -> one read at 0, bytes 00,11,...,FF on cycles 3..18, done=1 cycle 19.
REQ-033 Length=3, ByteReady=1 -> reads at 0,1,2; 48 bytes; prefetch build: ByteValid high 48 consecutive cycles; non-prefetch: two 2-cycle gaps.
REQ-034 Length=1, ByteReady low cycles 5-9 -> ByteOut frozen at 22, no byte lost or duplicated.
REQ-035 Length=4, StartIn dropped after 20 bytes -> IDLE next edge, done=1, no further ReadEnable.
REQ-036 Length=0 -> no ReadEnable, no ByteValid, done stays 1; BASE_ADDR=16'hFFFF, Length=2 -> reads at FFFF then 0000.
REQ-037 reset pulsed mid-DRAIN -> all outputs at REQ-026 values next cycle; restart yields correct stream.
